// File: rtl/source_ready_cam_pkg.sv
// rtl/source_ready_cam_pkg.sv - scheduler widths and tag/index types for the source-ready CAM
package source_ready_cam_pkg;

    localparam int ISSUE_QUEUE_ENTRY_NUM   = 16;
    localparam int DISPATCH_PORT_NUM       = 2;
    localparam int WAKEUP_PORT_NUM         = 4;
    localparam int SRC_NUM                 = 2;
    localparam int PHY_REG_NUM             = 64;

    localparam int SCHEDULER_REG_TAG_WIDTH = $clog2(PHY_REG_NUM);
    localparam int ISSUE_QUEUE_INDEX_WIDTH = $clog2(ISSUE_QUEUE_ENTRY_NUM);

    typedef logic [SCHEDULER_REG_TAG_WIDTH-1:0] scheduler_reg_tag_t;
    typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0] issue_queue_index_path_t;

endpackage

// File: rtl/source_ready_cam_entry.sv
// rtl/source_ready_cam_entry.sv - one issue-queue entry: wakeup tag compare plus valid/ready flops
module source_ready_cam_entry
    import source_ready_cam_pkg::*;
#(
    parameter int WAKEUP_WIDTH = WAKEUP_PORT_NUM
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 write,
    input  scheduler_reg_tag_t [SRC_NUM-1:0]     write_src_tag,
    input  logic [SRC_NUM-1:0]                   write_src_ready,
    input  logic [WAKEUP_WIDTH-1:0]              wakeup,
    input  scheduler_reg_tag_t [WAKEUP_WIDTH-1:0] wakeup_dst_tag,
    input  logic                                 release_entry,
    input  logic                                 flush,
    output logic                                 valid,
    output logic                                 op_ready
);

    scheduler_reg_tag_t [SRC_NUM-1:0] src_tag;
    logic [SRC_NUM-1:0]               src_ready;
    logic [SRC_NUM-1:0]               hit_stored;
    logic [SRC_NUM-1:0]               hit_new;

    // hit_new lets a wakeup racing the dispatch write land in the freshly loaded entry
    always_comb begin
        hit_stored = '0;
        hit_new    = '0;
        for (int s = 0; s < SRC_NUM; s++) begin
            for (int w = 0; w < WAKEUP_WIDTH; w++) begin
                if (wakeup[w] && (wakeup_dst_tag[w] == src_tag[s])) begin
                    hit_stored[s] = 1'b1;
                end
                if (wakeup[w] && (wakeup_dst_tag[w] == write_src_tag[s])) begin
                    hit_new[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            src_ready <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (write) begin
            valid     <= 1'b1;
            src_ready <= write_src_ready | hit_new;
        end else begin
            if (release_entry) begin
                valid <= 1'b0;
            end
            if (valid) begin
                src_ready <= src_ready | hit_stored;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write && !flush) begin
            src_tag <= write_src_tag;
        end
    end

    assign op_ready = valid & (&src_ready);

endmodule

// File: rtl/source_ready_cam.sv
// rtl/source_ready_cam.sv - issue-queue source-ready CAM with dispatch write ports and tag wakeup
module source_ready_cam
    import source_ready_cam_pkg::*;
#(
    parameter int ENTRY_NUM      = ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISPATCH_WIDTH = DISPATCH_PORT_NUM,
    parameter int WAKEUP_WIDTH   = WAKEUP_PORT_NUM,
    localparam int COUNT_WIDTH   = $clog2(ENTRY_NUM + 1)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0]                           write,
    input  issue_queue_index_path_t [DISPATCH_WIDTH-1:0]        write_ptr,
    input  scheduler_reg_tag_t [DISPATCH_WIDTH-1:0][SRC_NUM-1:0] write_src_tag,
    input  logic [DISPATCH_WIDTH-1:0][SRC_NUM-1:0]              write_src_ready,
    input  logic [WAKEUP_WIDTH-1:0]                             wakeup,
    input  scheduler_reg_tag_t [WAKEUP_WIDTH-1:0]               wakeup_dst_tag,
    input  logic [ENTRY_NUM-1:0]                                release_entry,
    input  logic                                                flush,
    output logic [ENTRY_NUM-1:0]                                op_ready,
    output logic [COUNT_WIDTH-1:0]                              valid_count
);

    logic [ENTRY_NUM-1:0]             entry_write;
    scheduler_reg_tag_t [SRC_NUM-1:0] entry_tag   [ENTRY_NUM];
    logic [SRC_NUM-1:0]               entry_ready [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]             valid;

    // Ports are scanned in ascending order so the highest-numbered port wins a collision
    always_comb begin
        for (int e = 0; e < ENTRY_NUM; e++) begin
            entry_write[e] = 1'b0;
            entry_tag[e]   = '0;
            entry_ready[e] = '0;
            for (int p = 0; p < DISPATCH_WIDTH; p++) begin
                if (write[p] && (write_ptr[p] == issue_queue_index_path_t'(e))) begin
                    entry_write[e] = 1'b1;
                    entry_tag[e]   = write_src_tag[p];
                    entry_ready[e] = write_src_ready[p];
                end
            end
        end
    end

    for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_entry
        source_ready_cam_entry #(
            .WAKEUP_WIDTH (WAKEUP_WIDTH)
        ) u_entry (
            .clk             (clk),
            .rst             (rst),
            .write           (entry_write[e]),
            .write_src_tag   (entry_tag[e]),
            .write_src_ready (entry_ready[e]),
            .wakeup          (wakeup),
            .wakeup_dst_tag  (wakeup_dst_tag),
            .release_entry   (release_entry[e]),
            .flush           (flush),
            .valid           (valid[e]),
            .op_ready        (op_ready[e])
        );
    end

    always_comb begin
        valid_count = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            valid_count = valid_count + COUNT_WIDTH'(valid[e]);
        end
    end

endmodule

// File: tb/tb_source_ready_cam.sv
// tb/tb_source_ready_cam.sv - self-checking bench for source_ready_cam against a behavioural model
module tb_source_ready_cam;
    import source_ready_cam_pkg::*;

    localparam int EN = 16;

    logic                                 clk = 1'b0;
    logic                                 rst = 1'b1;
    logic [1:0]                           write;
    issue_queue_index_path_t [1:0]        write_ptr;
    scheduler_reg_tag_t [1:0][1:0]        write_src_tag;
    logic [1:0][1:0]                      write_src_ready;
    logic [3:0]                           wakeup;
    scheduler_reg_tag_t [3:0]             wakeup_dst_tag;
    logic [EN-1:0]                        release_entry;
    logic                                 flush;
    logic [EN-1:0]                        op_ready;
    logic [4:0]                           valid_count;

    int tests = 0;
    int fails = 0;

    bit m_valid [EN];
    bit m_ready [EN][2];
    int m_tag   [EN][2];

    source_ready_cam dut (
        .clk             (clk),
        .rst             (rst),
        .write           (write),
        .write_ptr       (write_ptr),
        .write_src_tag   (write_src_tag),
        .write_src_ready (write_src_ready),
        .wakeup          (wakeup),
        .wakeup_dst_tag  (wakeup_dst_tag),
        .release_entry   (release_entry),
        .flush           (flush),
        .op_ready        (op_ready),
        .valid_count     (valid_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit woke(input int tag);
        for (int w = 0; w < 4; w++) begin
            if (wakeup[w] && (int'(wakeup_dst_tag[w]) == tag)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model: wakeups on live entries, then releases, then writes in port order, then flush
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < EN; e++) begin
                m_valid[e] = 1'b0;
                m_ready[e][0] = 1'b0;
                m_ready[e][1] = 1'b0;
            end
        end else begin
            for (int e = 0; e < EN; e++) begin
                if (m_valid[e]) begin
                    for (int s = 0; s < 2; s++) if (woke(m_tag[e][s])) m_ready[e][s] = 1'b1;
                end
            end
            for (int e = 0; e < EN; e++) if (release_entry[e]) m_valid[e] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (write[p]) begin
                    m_valid[write_ptr[p]] = 1'b1;
                    for (int s = 0; s < 2; s++) begin
                        m_tag[write_ptr[p]][s]   = int'(write_src_tag[p][s]);
                        m_ready[write_ptr[p]][s] = write_src_ready[p][s] | woke(int'(write_src_tag[p][s]));
                    end
                end
            end
            if (flush) for (int e = 0; e < EN; e++) m_valid[e] = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [EN-1:0] exp_ready;
        int exp_count;
        exp_count = 0;
        for (int e = 0; e < EN; e++) begin
            exp_ready[e] = m_valid[e] & m_ready[e][0] & m_ready[e][1];
            exp_count += int'(m_valid[e]);
        end
        check("model_op_ready", 32'(op_ready), 32'(exp_ready));
        check("model_valid_count", 32'(valid_count), 32'(exp_count));
    end

    task automatic clear_inputs();
        write           = '0;
        write_ptr       = '0;
        write_src_tag   = '0;
        write_src_ready = '0;
        wakeup          = '0;
        wakeup_dst_tag  = '0;
        release_entry   = '0;
        flush           = 1'b0;
    endtask

    task automatic set_write(input int p, input int idx, input int t0, input int t1,
                             input bit r0, input bit r1);
        write[p]              = 1'b1;
        write_ptr[p]          = issue_queue_index_path_t'(idx);
        write_src_tag[p][0]   = scheduler_reg_tag_t'(t0);
        write_src_tag[p][1]   = scheduler_reg_tag_t'(t1);
        write_src_ready[p][0] = r0;
        write_src_ready[p][1] = r1;
    endtask

    task automatic set_wakeup(input int p, input int tag);
        wakeup[p]         = 1'b1;
        wakeup_dst_tag[p] = scheduler_reg_tag_t'(tag);
    endtask

    task automatic cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_op_ready", 32'(op_ready), 32'h0);
        check("reset_valid_count", 32'(valid_count), 32'h0);
        rst = 1'b0;

        // Two-step wakeup of entry 3
        set_write(0, 3, 5, 9, 1'b0, 1'b0);
        cycle();
        check("wake_seq_c1", 32'(op_ready[3]), 32'h0);
        set_wakeup(0, 5);
        cycle();
        check("wake_seq_c2", 32'(op_ready[3]), 32'h0);
        set_wakeup(1, 9);
        cycle();
        check("wake_seq_c3", 32'(op_ready[3]), 32'h1);

        // Dispatch racing a wakeup
        set_write(0, 0, 12, 12, 1'b0, 1'b1);
        set_wakeup(2, 12);
        cycle();
        check("race_op_ready0", 32'(op_ready[0]), 32'h1);
        check("race_count", 32'(valid_count), 32'd2);

        // Duplicate tag on two wakeup ports
        set_write(0, 1, 20, 7, 1'b0, 1'b1);
        set_write(1, 4, 3, 20, 1'b1, 1'b0);
        cycle();
        set_write(0, 5, 21, 21, 1'b0, 1'b0);
        cycle();
        set_wakeup(0, 20);
        set_wakeup(3, 20);
        cycle();
        check("dup_wake_e1", 32'(op_ready[1]), 32'h1);
        check("dup_wake_e4", 32'(op_ready[4]), 32'h1);
        check("dup_wake_e5", 32'(op_ready[5]), 32'h0);
        check("dup_wake_count", 32'(valid_count), 32'd5);

        // Fill every entry
        for (int i = 0; i < EN; i += 2) begin
            set_write(0, i, 32 + $urandom_range(0, 7), 32 + $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_write(1, i + 1, 32 + $urandom_range(0, 7), 32 + $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
        end
        check("fill_count", 32'(valid_count), 32'd16);
        release_entry[7] = 1'b1;
        set_write(0, 7, 50, 51, 1'b1, 1'b0);
        cycle();
        check("rel_write_count", 32'(valid_count), 32'd16);
        check("rel_write_e7_pending", 32'(op_ready[7]), 32'h0);
        set_wakeup(1, 51);
        cycle();
        check("rel_write_e7_new_tag", 32'(op_ready[7]), 32'h1);

        // Down to ten entries, then flush against a write
        release_entry = 16'hfc00;
        cycle();
        check("ten_count", 32'(valid_count), 32'd10);
        flush = 1'b1;
        set_write(0, 2, 1, 2, 1'b1, 1'b1);
        cycle();
        check("flush_count", 32'(valid_count), 32'd0);
        check("flush_op_ready", 32'(op_ready), 32'h0);

        // Wakeup against invalid entries does nothing
        set_wakeup(0, 1);
        set_wakeup(1, 2);
        cycle();
        check("stale_wake_count", 32'(valid_count), 32'd0);

        // Random traffic, the model compare does the checking
        for (int c = 0; c < 400; c++) begin
            int i0;
            int i1;
            i0 = $urandom_range(0, EN - 1);
            i1 = (i0 + $urandom_range(1, EN - 1)) % EN;
            if ($urandom_range(0, 1) == 1) set_write(0, i0, $urandom_range(0, 15), $urandom_range(0, 15),
                                                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) set_write(1, i1, $urandom_range(0, 15), $urandom_range(0, 15),
                                                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int w = 0; w < 4; w++) if ($urandom_range(0, 1) == 1) set_wakeup(w, $urandom_range(0, 15));
            release_entry = EN'($urandom & $urandom & $urandom);
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end

        // Asynchronous reset mid-stream with six live entries
        flush = 1'b1;
        cycle();
        for (int i = 0; i < 6; i += 2) begin
            set_write(0, i, 40, 41, 1'b1, 1'b1);
            set_write(1, i + 1, 42, 43, 1'b1, 1'b1);
            cycle();
        end
        check("pre_rst_count", 32'(valid_count), 32'd6);
        check("pre_rst_op_ready", 32'(op_ready), 32'h003f);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_op_ready", 32'(op_ready), 32'h0);
        check("async_rst_count", 32'(valid_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_write(1, 9, 4, 4, 1'b1, 1'b1);
        cycle();
        check("post_rst_op_ready", 32'(op_ready), 32'h0200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
